lab3_mem_line_mem_responder: RTL
================================

// Module: lab3_mem_line_mem_responder
// PURPOSE
//  Memory-side responder for the 16B line interface the blocking cache drives on
//  cache2mem. Accepts one mem_req_16B_t at a time and performs it against an internal
//  line-wide storage array. After a programmable latency it returns one mem_resp_16B_t.
//  Serves as the main-memory model behind lab3_mem caches in unit and multi-core benches.
// PARAMETERS
//  p_num_lines  256  lines of 16B storage; power of two, >=2
//  p_latency    2    extra wait cycles between accept and response valid (0..15)
// PORTS
//  clk                 in   1    single clock, rising edge
//  reset               in   1    asynchronous, active-low reset (0 = in reset)
//  memreq_msg          in   175  mem_req_16B_t {type,opaque,addr,len,data}
//  memreq_val          in   1    request valid
//  memreq_rdy          out  1    request ready
//  memresp_msg         out  145  mem_resp_16B_t {type,opaque,test,len,data}
//  memresp_val         out  1    response valid
//  memresp_rdy         in   1    response ready
// BEHAVIOUR
//  - Line index = addr[4 +: $clog2(p_num_lines)]; addr[3:0] ignored (line-aligned).
//  - FSM: IDLE -> WAIT -> RESP -> IDLE; one request outstanding at most.
//    IDLE: memreq_rdy=1, memresp_val=0. On memreq_val&&memreq_rdy: latch type, opaque,
//      len and index. Perform the write/init at that edge.
//      Go to WAIT with counter=p_latency, or straight to RESP if p_latency==0.
//    WAIT: rdy=0, val=0. Decrement the counter each cycle; go to RESP when counter==1.
//    RESP: memresp_val=1, msg held stable; go to IDLE on memresp_rdy.
//      Never accept a request in the same cycle a response drains.
//  - Latency: accepted at edge T => memresp_val first high in cycle T+1+p_latency.
//    Back-to-back: the next accept occurs at the earliest one cycle after the response drains.
//  - READ(0): resp.data = line[index], read when entering RESP.
//  - WRITE(1) and INIT(2): len==0 writes all 16 bytes; len=n (1..15) writes bytes [n-1:0]
//    of the line only. resp.data=0.
//  - Other types (AMOs): no storage change; resp.data=0; type echoed.
//  - Response fields: type=latched type; opaque=latched opaque; len=latched len;
//    test=2'b00 unless the error feature flags it.
//  - Reset values: memresp_val=0, memresp_msg=0, memreq_rdy=0 while reset is low.
//    After release: FSM=IDLE, counter=0, and memreq_rdy=1 from the first cycle with reset high.
//  - Reset mid-operation aborts WAIT/RESP and drops the pending response.
//    A write committed at accept remains in storage.
//  - Storage contents are not reset; benches must INIT before reading.
//  - memresp_msg changes only on the entry to RESP; it is stable while val&&!rdy.
// CONFIGURATION
//  LAB3_MEM_LINE_MEM_RESPONDER_RANGE_CHECK_EN
//   defined: any addr bit above the index field being nonzero marks the request out of range.
//     An out-of-range request performs no storage access and responds with test=2'b11, data=0.
//     Latency and handshake are unchanged.
//   undefined: upper address bits are ignored (addresses alias modulo p_num_lines*16);
//     test is always 2'b00.
// TESTING
//  1 INIT addr 0x100 data 0xDEAD..BEEF len 0, then READ 0x100 opaque 0x05
//    -> READ resp type 0, opaque 0x05, data 0xDEAD..BEEF.
//  2 p_latency=2, READ accepted at edge 10 -> memresp_val first high in cycle 13;
//    memreq_rdy low in cycles 11-13.
//  3 memresp_rdy held low 5 cycles in RESP -> val stays 1 and msg stable.
//    rdy=1 -> next cycle IDLE with memreq_rdy=1.
//  4 WRITE 0x200 len 4 data 0x...11223344 over line of all 0xFF
//    -> READ returns 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1122_3344.
//  5 Assert reset low during WAIT of a WRITE -> memresp_val=0 immediately.
//    After release, no response appears; READ shows the written data.
//  6 RANGE_CHECK_EN, p_num_lines=256, READ 0x0001_0000
//    -> resp test=2'b11, data 0; line 0 unchanged. Without the macro it aliases line 0.

Source files
------------

// File: rtl/lab3_mem_line_mem_responder.sv
// Line-wide main-memory model behind the lab3_mem caches: one request in flight,
// fixed latency. Optional LAB3_MEM_LINE_MEM_RESPONDER_RANGE_CHECK_EN flags out-of-range addresses.

package lab3_mem_line_mem_responder_pkg;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

module lab3_mem_line_mem_responder
  import lab3_mem_line_mem_responder_pkg::*;
#(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [174:0] memreq_msg,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  output logic [144:0] memresp_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy
);

  localparam int         IW  = $clog2(p_num_lines);
  localparam logic [3:0] LAT = 4'(p_latency);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          val_q;
  mem_resp_16B_t resp_q;
  mem_resp_16B_t resp_d;

  logic [2:0]    typ_q;
  logic [7:0]    opq_q;
  logic [3:0]    len_q;
  logic [IW-1:0] idx_q;
  logic          oor_q;

  mem_req_16B_t  req;
  logic [IW-1:0] req_idx;
  logic          req_oor;
  logic          accept;
  logic          wr_en;
  logic [15:0]   be;

  logic [2:0]    src_typ;
  logic [7:0]    src_opq;
  logic [3:0]    src_len;
  logic [IW-1:0] src_idx;
  logic          src_oor;

  logic [127:0]  mem_q [p_num_lines];

  assign req     = mem_req_16B_t'(memreq_msg);
  assign req_idx = req.addr[4 +: IW];

`ifdef LAB3_MEM_LINE_MEM_RESPONDER_RANGE_CHECK_EN
  assign req_oor = |(req.addr >> (4 + IW));
`else
  assign req_oor = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{req.addr[3:0], req.addr[31:4+IW]};

  assign memreq_rdy  = reset & (state_q == S_IDLE);
  assign accept      = memreq_val & memreq_rdy;
  assign memresp_val = val_q;
  assign memresp_msg = resp_q;

  // len==0 means a full line; otherwise the low len bytes
  always_comb begin
    be = '0;
    for (int b = 0; b < 16; b++) begin
      be[b] = (req.len == 4'd0) || (4'(b) < req.len);
    end
  end

  assign wr_en = accept && !req_oor &&
                 (req.typ == MEM_WRITE || req.typ == MEM_INIT);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (be[b]) mem_q[req_idx][8*b +: 8] <= req.data[8*b +: 8];
      end
    end
  end

  // zero-latency responses are built from the live request
  assign src_typ = (state_q == S_IDLE) ? req.typ    : typ_q;
  assign src_opq = (state_q == S_IDLE) ? req.opaque : opq_q;
  assign src_len = (state_q == S_IDLE) ? req.len    : len_q;
  assign src_idx = (state_q == S_IDLE) ? req_idx    : idx_q;
  assign src_oor = (state_q == S_IDLE) ? req_oor    : oor_q;

  always_comb begin
    resp_d        = '0;
    resp_d.typ    = src_typ;
    resp_d.opaque = src_opq;
    resp_d.len    = src_len;
    resp_d.test   = src_oor ? 2'b11 : 2'b00;
    if (src_typ == MEM_READ && !src_oor) begin
      resp_d.data = mem_q[src_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      resp_q  <= '0;
      typ_q   <= '0;
      opq_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            typ_q <= req.typ;
            opq_q <= req.opaque;
            len_q <= req.len;
            idx_q <= req_idx;
            oor_q <= req_oor;
            if (LAT == 4'd0) begin
              state_q <= S_RESP;
              val_q   <= 1'b1;
              resp_q  <= resp_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
            val_q   <= 1'b1;
            resp_q  <= resp_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (memresp_rdy) begin
            state_q <= S_IDLE;
            val_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
